// File: rtl/keypad_emu.sv
// keypad_emu
// Emulates a 4x4 matrix keypad for a row-scanning controller. A key-press
// command selects a key and a hold time; the emulator then closes that
// contact with a bounce burst, holds it, releases it with a second bounce
// burst, and enforces a quiet gap before the next key can be pressed.
//
// Ports:
//   mclk         clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   keyout[3:0]  row drive from the scanner, 0 = row driven low
//   keyin[3:0]   column return to the scanner, 0 = closed contact
//   cmd_valid    key-press command offered
//   cmd_ready    command accepted this cycle (IDLE and no abort)
//   cmd_key      key code 1..16, other values rejected with cmd_err
//   cmd_hold_ms  hold time in ms ticks, 0 behaves as 1
//   abort        release the key immediately, skipping bounce and gap
//   busy         high in every state other than IDLE
//   pressed_code latched key while the contact is closed, else 0
//   cmd_err      one-cycle pulse after an invalid key was accepted
module keypad_emu #(
  parameter int TICK_CYCLES   = 32000,
  parameter int BOUNCE_CYCLES = 1600,
  parameter int BOUNCE_EDGES  = 6,
  parameter int GAP_TICKS     = 20
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [3:0] keyout,
  output logic [3:0] keyin,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_key,
  input  logic [7:0] cmd_hold_ms,
  input  logic       abort,
  output logic       busy,
  output logic [4:0] pressed_code,
  output logic       cmd_err
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] BOUNCE_IN  = 3'd1;
  localparam logic [2:0] HOLD       = 3'd2;
  localparam logic [2:0] BOUNCE_OUT = 3'd3;
  localparam logic [2:0] GAP        = 3'd4;

  // The down-counter must cover the longest single phase: a 255 ms hold,
  // the release gap, or one bounce interval.
  localparam longint HOLD_MAX = 64'd255 * longint'(TICK_CYCLES);
  localparam longint GAP_LEN  = longint'(GAP_TICKS) * longint'(TICK_CYCLES);
  localparam longint MAX_A    = (HOLD_MAX > GAP_LEN) ? HOLD_MAX : GAP_LEN;
  localparam longint CNT_MAX  = (MAX_A > longint'(BOUNCE_CYCLES)) ? MAX_A : longint'(BOUNCE_CYCLES);
  localparam int     CW       = $clog2(CNT_MAX + 1);
  localparam int     EW       = (BOUNCE_EDGES < 2) ? 1 : $clog2(BOUNCE_EDGES + 1);

  localparam logic [CW-1:0] BOUNCE_LOAD = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_LEN - 1);
  localparam logic [EW-1:0] EDGE_LAST   = EW'(BOUNCE_EDGES - 1);
  // With no gap configured the release goes straight back to IDLE.
  localparam logic [2:0]    REL_NEXT    = (GAP_TICKS == 0) ? IDLE : GAP;

  logic [2:0]    state;
  logic          contact;
  logic [4:0]    key;
  logic [7:0]    hold_ms;
  logic [CW-1:0] cnt;
  logic [EW-1:0] edges;

  logic          handshake;
  logic          key_ok;
  logic [7:0]    cmd_hold_eff;
  logic [7:0]    hold_src;
  logic [CW-1:0] hold_load;
  logic [3:0]    key_idx;
  logic [1:0]    row;
  logic [1:0]    col;

  assign cmd_ready    = rst_n && (state == IDLE) && !abort;
  assign handshake    = cmd_valid && cmd_ready;
  assign key_ok       = (cmd_key != 5'd0) && (cmd_key <= 5'd16);
  assign busy         = (state != IDLE);
  assign pressed_code = contact ? key : 5'd0;

  // HOLD can be entered straight from IDLE when bouncing is disabled, so the
  // hold length comes from the command in that case and from the latch later.
  assign cmd_hold_eff = (cmd_hold_ms == 8'd0) ? 8'd1 : cmd_hold_ms;
  assign hold_src     = (state == IDLE) ? cmd_hold_eff : hold_ms;
  assign hold_load    = CW'(hold_src) * CW'(TICK_CYCLES) - CW'(1);

  // Key 16 wraps to index 15 in four bits, giving row 3 / column 3.
  assign key_idx = key[3:0] - 4'd1;
  assign row     = key_idx[3:2];
  assign col     = key_idx[1:0];

  // Column return is purely combinational so the scanner sees the contact in
  // the same cycle it drives the row.
  always_comb begin
    keyin = 4'b1111;
    if (contact && !keyout[row]) keyin[col] = 1'b0;
  end

  // Press sequencer: every phase is timed by one down-counter loaded with
  // (length - 1) on entry; bounce phases also count contact toggles.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state   <= IDLE;
      contact <= 1'b0;
      key     <= 5'd0;
      hold_ms <= 8'd0;
      cnt     <= '0;
      edges   <= '0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            if (key_ok) begin
              key     <= cmd_key;
              hold_ms <= cmd_hold_eff;
              contact <= 1'b1;
              edges   <= '0;
              if (BOUNCE_EDGES == 0) begin
                state <= HOLD;
                cnt   <= hold_load;
              end else begin
                state <= BOUNCE_IN;
                cnt   <= BOUNCE_LOAD;
              end
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        BOUNCE_IN: begin
          if (cnt == '0) begin
            contact <= ~contact;
            if (edges == EDGE_LAST) begin
              state <= HOLD;
              cnt   <= hold_load;
              edges <= '0;
            end else begin
              cnt   <= BOUNCE_LOAD;
              edges <= edges + EW'(1);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            contact <= 1'b0;
            edges   <= '0;
            if (BOUNCE_EDGES == 0) begin
              state <= REL_NEXT;
              cnt   <= GAP_LOAD;
            end else begin
              state <= BOUNCE_OUT;
              cnt   <= BOUNCE_LOAD;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BOUNCE_OUT: begin
          if (cnt == '0) begin
            contact <= ~contact;
            if (edges == EDGE_LAST) begin
              state <= REL_NEXT;
              cnt   <= GAP_LOAD;
              edges <= '0;
            end else begin
              cnt   <= BOUNCE_LOAD;
              edges <= edges + EW'(1);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: begin
          state   <= IDLE;
          contact <= 1'b0;
        end
      endcase
      // Abort overrides whatever the phase logic chose above.
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        contact <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_emu.sv
// tb_keypad_emu
// Self-checking bench for keypad_emu with small timing parameters. A model
// pushes the expected per-cycle busy / pressed_code / cmd_ready / cmd_err
// trace of each command into a queue as the command is driven; each test
// pops that trace cycle by cycle and compares it with the DUT outputs.
module tb_keypad_emu;

  localparam int TICK = 10;
  localparam int BC   = 2;
  localparam int BE   = 2;
  localparam int GT   = 1;

  typedef struct {
    logic       busy;
    logic [4:0] code;
    logic       ready;
    logic       err;
  } exp_t;

  logic       mclk = 1'b0;
  logic       rst_n;
  logic [3:0] keyout;
  logic [3:0] keyin;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_key;
  logic [7:0] cmd_hold_ms;
  logic       abort;
  logic       busy;
  logic [4:0] pressed_code;
  logic       cmd_err;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  keypad_emu #(
    .TICK_CYCLES  (TICK),
    .BOUNCE_CYCLES(BC),
    .BOUNCE_EDGES (BE),
    .GAP_TICKS    (GT)
  ) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .keyout      (keyout),
    .keyin       (keyin),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_key     (cmd_key),
    .cmd_hold_ms (cmd_hold_ms),
    .abort       (abort),
    .busy        (busy),
    .pressed_code(pressed_code),
    .cmd_err     (cmd_err)
  );

  always #5 mclk = ~mclk;

  // Expected column return for a closed key code under a given row drive.
  function automatic logic [3:0] exp_keyin(input logic [4:0] code, input logic [3:0] ko);
    logic [3:0] r;
    int idx;
    r = 4'b1111;
    if (code != 5'd0) begin
      idx = int'(code) - 1;
      if (ko[idx / 4] == 1'b0) r[idx % 4] = 1'b0;
    end
    return r;
  endfunction

  // Pushes the trace for cycles T+1.. of a valid press; limit > 0 truncates
  // it (abort/reset cases) and drops the trailing idle cycle.
  task automatic push_press(input int k, input int hold, input int limit);
    int eh, bp, hl, len, n;
    eh  = (hold == 0) ? 1 : hold;
    bp  = BE * BC;
    hl  = eh * TICK;
    len = 2 * bp + hl + GT * TICK;
    n   = (limit > 0 && limit < len) ? limit : len;
    for (int i = 1; i <= n; i++) begin
      logic c;
      if (i <= bp)               c = (((i - 1) / BC) % 2) == 0;
      else if (i <= bp + hl)     c = 1'b1;
      else if (i <= 2 * bp + hl) c = (((i - bp - hl - 1) / BC) % 2) == 1;
      else                       c = 1'b0;
      sb.push_back('{1'b1, c ? 5'(k) : 5'd0, 1'b0, 1'b0});
    end
    if (n == len) sb.push_back('{1'b0, 5'd0, 1'b1, 1'b0});
  endtask

  // Offers one command in the current (idle) cycle and withdraws it after
  // the handshake edge.
  task automatic offer_cmd(input int k, input int hold);
    cmd_valid   = 1'b1;
    cmd_key     = 5'(k);
    cmd_hold_ms = 8'(hold);
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (pressed_code !== 5'd0) begin errors++; $display("[TB] FAIL reset_code got %0d want 0", pressed_code); end
    checks++;
    if (keyin !== 4'b1111) begin errors++; $display("[TB] FAIL reset_keyin got %b want 1111", keyin); end
    checks++;
    if (cmd_ready !== 1'b0 || cmd_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready_err got %b%b want 00", cmd_ready, cmd_err);
    end
    @(posedge mclk); #1;
    rst_n = 1'b1;
    @(negedge mclk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready got %b want 1", cmd_ready); end
    @(posedge mclk); #1;
  endtask

  task automatic test_full_press;
    exp_t e;
    keyout = 4'b1101;
    push_press(6, 3, 0);
    offer_cmd(6, 3);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || pressed_code !== e.code || cmd_ready !== e.ready ||
          cmd_err !== e.err || keyin !== exp_keyin(e.code, keyout)) begin
        errors++;
        $display("[TB] FAIL full_press cyc %0d got busy=%b code=%0d rdy=%b err=%b keyin=%b want %b %0d %b %b %b",
                 i, busy, pressed_code, cmd_ready, cmd_err, keyin, e.busy, e.code, e.ready, e.err,
                 exp_keyin(e.code, keyout));
      end
      if (i == 20) begin
        keyout = 4'b1011;
        #1;
        checks++;
        if (keyin !== 4'b1111) begin errors++; $display("[TB] FAIL row_released_keyin got %b want 1111", keyin); end
      end
      if (i == 25) keyout = 4'b1101;
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_invalid_keys;
    exp_t e;
    keyout = 4'b0000;
    sb.push_back('{1'b0, 5'd0, 1'b1, 1'b1});
    sb.push_back('{1'b0, 5'd0, 1'b1, 1'b0});
    offer_cmd(0, 5);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || cmd_ready !== e.ready || cmd_err !== e.err || keyin !== 4'b1111) begin
        errors++;
        $display("[TB] FAIL bad_key0 cyc %0d got busy=%b rdy=%b err=%b keyin=%b want %b %b %b 1111",
                 i, busy, cmd_ready, cmd_err, keyin, e.busy, e.ready, e.err);
      end
    end
    @(posedge mclk); #1;
    sb.push_back('{1'b0, 5'd0, 1'b1, 1'b1});
    sb.push_back('{1'b0, 5'd0, 1'b1, 1'b0});
    offer_cmd(17, 5);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || cmd_ready !== e.ready || cmd_err !== e.err || keyin !== 4'b1111) begin
        errors++;
        $display("[TB] FAIL bad_key17 cyc %0d got busy=%b rdy=%b err=%b keyin=%b want %b %b %b 1111",
                 i, busy, cmd_ready, cmd_err, keyin, e.busy, e.ready, e.err);
      end
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_zero_hold;
    exp_t e;
    keyout = 4'b0111;
    push_press(16, 0, 0);
    offer_cmd(16, 0);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || pressed_code !== e.code || cmd_ready !== e.ready ||
          keyin !== exp_keyin(e.code, keyout)) begin
        errors++;
        $display("[TB] FAIL zero_hold cyc %0d got busy=%b code=%0d rdy=%b keyin=%b want %b %0d %b %b",
                 i, busy, pressed_code, cmd_ready, keyin, e.busy, e.code, e.ready,
                 exp_keyin(e.code, keyout));
      end
      keyout[3] = ~keyout[3];
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_abort;
    exp_t e;
    keyout = 4'b0000;
    abort  = 1'b1;
    @(negedge mclk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_abort got rdy=%b busy=%b want 0 0", cmd_ready, busy);
    end
    @(posedge mclk); #1;
    abort = 1'b0;
    push_press(6, 3, 20);
    offer_cmd(6, 3);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || pressed_code !== e.code || keyin !== exp_keyin(e.code, keyout)) begin
        errors++;
        $display("[TB] FAIL pre_abort cyc %0d got busy=%b code=%0d keyin=%b want %b %0d %b",
                 i, busy, pressed_code, keyin, e.busy, e.code, exp_keyin(e.code, keyout));
      end
    end
    abort = 1'b1;
    @(posedge mclk); #1;
    abort = 1'b0;
    push_press(3, 1, 0);
    cmd_valid   = 1'b1;
    cmd_key     = 5'd3;
    cmd_hold_ms = 8'd1;
    @(negedge mclk);
    checks++;
    if (busy !== 1'b0 || pressed_code !== 5'd0 || keyin !== 4'b1111 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_abort got busy=%b code=%0d keyin=%b rdy=%b want 0 0 1111 1",
               busy, pressed_code, keyin, cmd_ready);
    end
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || pressed_code !== e.code || cmd_ready !== e.ready) begin
        errors++;
        $display("[TB] FAIL after_abort_press cyc %0d got busy=%b code=%0d rdy=%b want %b %0d %b",
                 i, busy, pressed_code, cmd_ready, e.busy, e.code, e.ready);
      end
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_reset_mid_press;
    exp_t e;
    keyout = 4'b0000;
    push_press(6, 3, 10);
    offer_cmd(6, 3);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || pressed_code !== e.code) begin
        errors++;
        $display("[TB] FAIL pre_reset cyc %0d got busy=%b code=%0d want %b %0d", i, busy, pressed_code, e.busy, e.code);
      end
    end
    rst_n = 1'b0;
    @(posedge mclk); #1;
    @(negedge mclk);
    checks++;
    if (busy !== 1'b0 || pressed_code !== 5'd0 || keyin !== 4'b1111 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got busy=%b code=%0d keyin=%b rdy=%b want 0 0 1111 0",
               busy, pressed_code, keyin, cmd_ready);
    end
    @(posedge mclk); #1;
    rst_n = 1'b1;
    @(negedge mclk);
    checks++;
    if (busy !== 1'b0 || keyin !== 4'b1111 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_reset got busy=%b keyin=%b rdy=%b want 0 1111 1", busy, keyin, cmd_ready);
    end
    @(posedge mclk); #1;
  endtask

  // Second command is held on the bus during the first press and must only
  // be taken in the idle cycle that follows it.
  task automatic test_back_to_back;
    exp_t e;
    int   n1;
    keyout = 4'b0000;
    push_press(1, 1, 0);
    n1 = sb.size();
    offer_cmd(1, 1);
    cmd_valid   = 1'b1;
    cmd_key     = 5'd11;
    cmd_hold_ms = 8'd2;
    push_press(11, 2, 0);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge mclk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || pressed_code !== e.code || cmd_ready !== e.ready ||
          keyin !== exp_keyin(e.code, keyout)) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc %0d got busy=%b code=%0d rdy=%b keyin=%b want %b %0d %b %b",
                 i, busy, pressed_code, cmd_ready, keyin, e.busy, e.code, e.ready,
                 exp_keyin(e.code, keyout));
      end
      if (i == n1) begin
        @(posedge mclk); #1;
        cmd_valid = 1'b0;
      end
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_random_presses;
    exp_t e;
    int   k, h;
    keyout = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      k = $urandom_range(16, 1);
      h = $urandom_range(2, 0);
      push_press(k, h, 0);
      offer_cmd(k, h);
      for (int i = 1; sb.size() > 0; i++) begin
        @(negedge mclk);
        e = sb.pop_front();
        checks++;
        if (busy !== e.busy || pressed_code !== e.code || cmd_ready !== e.ready ||
            keyin !== exp_keyin(e.code, keyout)) begin
          errors++;
          $display("[TB] FAIL random key %0d hold %0d cyc %0d got busy=%b code=%0d rdy=%b keyin=%b want %b %0d %b %b",
                   k, h, i, busy, pressed_code, cmd_ready, keyin, e.busy, e.code, e.ready,
                   exp_keyin(e.code, keyout));
        end
      end
      @(posedge mclk); #1;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    keyout      = 4'b0000;
    cmd_valid   = 1'b0;
    cmd_key     = 5'd0;
    cmd_hold_ms = 8'd0;
    abort       = 1'b0;
    test_reset;
    test_full_press;
    test_invalid_keys;
    test_zero_hold;
    test_abort;
    test_reset_mid_press;
    test_back_to_back;
    test_random_presses;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
